// File: rtl/a2f_pkg.sv
// a2f_pkg -- shared definitions for the FTDI packet scheduler.
// Holds the mode encoding, the default widths and the packet-boundary
// arbitration function. The sequence tag width is used only when the
// A2F_PKT_TAG_EN macro is defined.
package a2f_pkg;

   localparam int A2F_FT_DATA_WIDTH    = 32;
   localparam int A2F_IQ_PAIR_WIDTH    = 24;
   localparam int A2F_QSTART_BIT_INDEX = 16;
   localparam int A2F_PKT_WORDS        = 256;
   localparam int A2F_SEQ_W            = 3;

   typedef enum logic {
      FROMFIFO = 1'b0,
      FROMCPU  = 1'b1
   } a2f_mode_e;

   // Source for the next packet. The CPU wins whenever it has data, except
   // that a CPU packet is always followed by a FIFO packet when the FIFO is
   // also waiting, so the sample stream cannot be starved.
   function automatic a2f_mode_e a2f_next_mode(input a2f_mode_e mode,
                                               input logic      fifo_empty,
                                               input logic      cpu_empty);
      a2f_mode_e nxt;
      nxt = FROMFIFO;
      if (!cpu_empty && !((mode == FROMCPU) && !fifo_empty))
         nxt = FROMCPU;
      return nxt;
   endfunction

endpackage

// File: rtl/a2f_iq_pack.sv
// a2f_iq_pack -- combinational placement of a packed I/Q pair in an FTDI word.
// The I half goes to QSTART_BIT_INDEX upward, the Q half to bit 0 upward,
// every other bit is zero. With A2F_PKT_TAG_EN defined the top bit flags the
// first word of a packet and the next three bits carry the packet sequence.
module a2f_iq_pack
   import a2f_pkg::*;
#(
   parameter int FT_DATA_WIDTH    = A2F_FT_DATA_WIDTH,
   parameter int IQ_PAIR_WIDTH    = A2F_IQ_PAIR_WIDTH,
   parameter int QSTART_BIT_INDEX = A2F_QSTART_BIT_INDEX
) (
   input  logic [IQ_PAIR_WIDTH-1:0] iq,
`ifdef A2F_PKT_TAG_EN
   input  logic                     first_word,
   input  logic [A2F_SEQ_W-1:0]     seq,
`endif
   output logic [FT_DATA_WIDTH-1:0] word
);

   localparam int HALF = IQ_PAIR_WIDTH / 2;

   // Build the outgoing word from zero so unused bits stay clean.
   always_comb begin
      word = '0;
      word[QSTART_BIT_INDEX +: HALF] = iq[IQ_PAIR_WIDTH-1 -: HALF];
      word[0 +: HALF]                = iq[HALF-1:0];
`ifdef A2F_PKT_TAG_EN
      word[FT_DATA_WIDTH-1]              = first_word;
      word[FT_DATA_WIDTH-2 -: A2F_SEQ_W] = seq;
`endif
   end

endmodule

// File: rtl/a2f_pkt_sched.sv
// a2f_pkt_sched -- packet scheduler feeding the FTDI from two FWFT sources:
// the I/Q sample FIFO and the CPU queue. Sources are switched only at packet
// boundaries of PKT_WORDS words. Optional macro: A2F_PKT_TAG_EN adds a
// first-word flag and packet sequence number to FIFO words.
//
// Handshake: each source presents a first-word-fall-through word with an
// empty flag (valid = ~empty); re_i is the FTDI's ready. A word is accepted
// in a cycle where re_i is high and the selected source is non-empty; only
// then does the matching read strobe fire, the word counter advance and
// data_o load one cycle later. re_i against an empty selected source is an
// underflow and changes nothing but underflow_o.
module a2f_pkt_sched
   import a2f_pkg::*;
#(
   parameter int FT_DATA_WIDTH    = A2F_FT_DATA_WIDTH,
   parameter int IQ_PAIR_WIDTH    = A2F_IQ_PAIR_WIDTH,
   parameter int QSTART_BIT_INDEX = A2F_QSTART_BIT_INDEX,
   parameter int PKT_WORDS        = A2F_PKT_WORDS
) (
   input  logic                     clk_i,
   input  logic                     reset_n,
   input  logic                     re_i,
   input  logic [IQ_PAIR_WIDTH-1:0] fifo_data_i,
   input  logic                     fifo_empty_i,
   output logic                     fifo_re_o,
   input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
   input  logic                     cpu_empty_i,
   output logic                     cpu_re_o,
   output logic [FT_DATA_WIDTH-1:0] data_o,
   output logic                     avail_o,
   output logic                     mode_o,
   output logic                     underflow_o
);

   localparam int              CNT_W     = $clog2(PKT_WORDS);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PKT_WORDS - 1);

   a2f_mode_e                mode_q;
   logic [CNT_W-1:0]         count_q;
   logic [FT_DATA_WIDTH-1:0] data_q;
   logic                     underflow_q;

   logic                     sel_empty;
   logic                     read_ok;
   logic                     last_word;
   logic [FT_DATA_WIDTH-1:0] fifo_word;

   // Empty flag of the source owning the current packet.
   always_comb begin
      sel_empty = fifo_empty_i;
      if (mode_q == FROMCPU)
         sel_empty = cpu_empty_i;
   end

   // Accepted read; gated by reset so no strobe can leak out while held.
   assign read_ok   = re_i & ~sel_empty & reset_n;
   assign last_word = (count_q == LAST_WORD);

   assign fifo_re_o   = read_ok & (mode_q == FROMFIFO);
   assign cpu_re_o    = read_ok & (mode_q == FROMCPU);
   assign avail_o     = ~sel_empty;
   assign mode_o      = mode_q;
   assign data_o      = data_q;
   assign underflow_o = underflow_q;

`ifdef A2F_PKT_TAG_EN
   logic [A2F_SEQ_W-1:0] seq_q;

   // Sequence number advances once per completed FIFO packet.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n)
         seq_q <= '0;
      else if (read_ok && last_word && (mode_q == FROMFIFO))
         seq_q <= seq_q + A2F_SEQ_W'(1);
   end

   a2f_iq_pack #(
      .FT_DATA_WIDTH    (FT_DATA_WIDTH),
      .IQ_PAIR_WIDTH    (IQ_PAIR_WIDTH),
      .QSTART_BIT_INDEX (QSTART_BIT_INDEX)
   ) u_pack (
      .iq         (fifo_data_i),
      .first_word (count_q == '0),
      .seq        (seq_q),
      .word       (fifo_word)
   );
`else
   a2f_iq_pack #(
      .FT_DATA_WIDTH    (FT_DATA_WIDTH),
      .IQ_PAIR_WIDTH    (IQ_PAIR_WIDTH),
      .QSTART_BIT_INDEX (QSTART_BIT_INDEX)
   ) u_pack (
      .iq   (fifo_data_i),
      .word (fifo_word)
   );
`endif

   // Mode FSM with word counter, output data and underflow registers.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         mode_q      <= FROMFIFO;
         count_q     <= '0;
         data_q      <= '0;
         underflow_q <= 1'b0;
      end else begin
         underflow_q <= re_i & sel_empty;
         if (read_ok) begin
            count_q <= count_q + CNT_W'(1);
            data_q  <= (mode_q == FROMCPU) ? cpu_data_i : fifo_word;
            if (last_word)
               mode_q <= a2f_next_mode(mode_q, fifo_empty_i, cpu_empty_i);
         end
      end
   end

endmodule

// File: tb/tb_a2f_pkt_sched.sv
// tb_a2f_pkt_sched -- directed bench for the FTDI packet scheduler.
// Expected FIFO words come from a small packing model; when compiled with
// A2F_PKT_TAG_EN the model adds the first-word flag and sequence number.
module tb_a2f_pkt_sched;

   logic        clk_i = 1'b0;
   logic        reset_n;
   logic        re_i;
   logic [23:0] fifo_data_i;
   logic        fifo_empty_i;
   logic        fifo_re_o;
   logic [31:0] cpu_data_i;
   logic        cpu_empty_i;
   logic        cpu_re_o;
   logic [31:0] data_o;
   logic        avail_o;
   logic        mode_o;
   logic        underflow_o;

   int n_chk  = 0;
   int n_fail = 0;

   a2f_pkt_sched dut (
      .clk_i        (clk_i),
      .reset_n      (reset_n),
      .re_i         (re_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_re_o    (fifo_re_o),
      .cpu_data_i   (cpu_data_i),
      .cpu_empty_i  (cpu_empty_i),
      .cpu_re_o     (cpu_re_o),
      .data_o       (data_o),
      .avail_o      (avail_o),
      .mode_o       (mode_o),
      .underflow_o  (underflow_o)
   );

   // Clock
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] exp_fifo(input logic [23:0] iq, input int word, input int seq);
      logic [31:0] w;
      w = {8'h00, iq[23:12], 4'h0, iq[11:0]};
`ifdef A2F_PKT_TAG_EN
      w[31]    = (word == 0);
      w[30:28] = 3'(seq);
`endif
      return w;
   endfunction

   function automatic logic [23:0] iq_of(input int w, input int salt);
      return {12'(w + salt), 12'(~w)};
   endfunction

   initial begin
      logic [31:0] last_data;
      int          fifo_seq;
      fifo_seq = 0;

      // Reset: outputs cleared, strobe held low even with a request pending.
      reset_n      = 1'b0;
      re_i         = 1'b1;
      fifo_data_i  = 24'h0;
      fifo_empty_i = 1'b0;
      cpu_data_i   = 32'h0;
      cpu_empty_i  = 1'b1;
      tick();
      tick();
      chk("rst_data", data_o, 32'h0);
      chk("rst_mode", {31'b0, mode_o}, 32'h0);
      chk("rst_underflow", {31'b0, underflow_o}, 32'h0);
      chk("rst_fifo_re", {31'b0, fifo_re_o}, 32'h0);
      re_i    = 1'b0;
      reset_n = 1'b1;
      tick();

      // Single FIFO read, word 0 of the first packet.
      fifo_data_i  = 24'hABC123;
      re_i         = 1'b1;
      #1;
      chk("w0_fifo_re", {31'b0, fifo_re_o}, 32'h1);
      chk("w0_cpu_re", {31'b0, cpu_re_o}, 32'h0);
      chk("w0_avail", {31'b0, avail_o}, 32'h1);
      tick();
      re_i = 1'b0;
      #1;
      chk("w0_data", data_o, exp_fifo(24'hABC123, 0, 0));
`ifndef A2F_PKT_TAG_EN
      chk("w0_data_lit", data_o, 32'h0ABC_0123);
`endif
      chk("w0_fifo_re_off", {31'b0, fifo_re_o}, 32'h0);
      last_data = data_o;

      // Underflow: FIFO selected but empty.
      fifo_empty_i = 1'b1;
      re_i         = 1'b1;
      #1;
      chk("uf_fifo_re", {31'b0, fifo_re_o}, 32'h0);
      chk("uf_avail", {31'b0, avail_o}, 32'h0);
      tick();
      chk("uf_pulse", {31'b0, underflow_o}, 32'h1);
      chk("uf_data_hold", data_o, last_data);
      re_i = 1'b0;
      tick();
      chk("uf_pulse_end", {31'b0, underflow_o}, 32'h0);

      // Rest of the FIFO packet; CPU wakes up at word 10 but must wait.
      fifo_empty_i = 1'b0;
      re_i         = 1'b1;
      for (int w = 1; w < 256; w++) begin
         if (w == 10) cpu_empty_i = 1'b0;
         fifo_data_i = iq_of(w, 0);
         cpu_data_i  = 32'hC0DE_0000 | 32'(w);
         #1;
         chk($sformatf("p0_mode_w%0d", w), {31'b0, mode_o}, 32'h0);
         tick();
         chk($sformatf("p0_data_w%0d", w), data_o, exp_fifo(iq_of(w, 0), w, fifo_seq));
      end
      fifo_seq++;
      chk("p0_boundary_mode", {31'b0, mode_o}, 32'h1);

      // Both sources busy: CPU packet, then FIFO packet, then CPU again.
      for (int w = 0; w < 256; w++) begin
         cpu_data_i  = 32'hF00D_0000 | 32'(w);
         fifo_data_i = iq_of(w, 1);
         #1;
         chk($sformatf("p1_mode_w%0d", w), {31'b0, mode_o}, 32'h1);
         if (w == 0) begin
            chk("p1_cpu_re", {31'b0, cpu_re_o}, 32'h1);
            chk("p1_fifo_re", {31'b0, fifo_re_o}, 32'h0);
         end
         tick();
         chk($sformatf("p1_data_w%0d", w), data_o, 32'hF00D_0000 | 32'(w));
      end
      chk("p1_boundary_mode", {31'b0, mode_o}, 32'h0);

      for (int w = 0; w < 256; w++) begin
         fifo_data_i = iq_of(w, 2);
         #1;
         chk($sformatf("p2_mode_w%0d", w), {31'b0, mode_o}, 32'h0);
         tick();
         chk($sformatf("p2_data_w%0d", w), data_o, exp_fifo(iq_of(w, 2), w, fifo_seq));
      end
      fifo_seq++;
      chk("p2_boundary_mode", {31'b0, mode_o}, 32'h1);

      // CPU packet cut short by reset after word 99 has been taken.
      for (int w = 0; w < 100; w++) begin
         cpu_data_i = 32'h1234_0000 | 32'(w);
         tick();
      end
      chk("p3_data_w99", data_o, 32'h1234_0063);
      reset_n = 1'b0;
      #1;
      chk("p3_rst_mode", {31'b0, mode_o}, 32'h0);
      chk("p3_rst_data", data_o, 32'h0);
      chk("p3_rst_cpu_re", {31'b0, cpu_re_o}, 32'h0);
      chk("p3_rst_fifo_re", {31'b0, fifo_re_o}, 32'h0);
      tick();
      chk("p3_rst_hold", data_o, 32'h0);
      reset_n  = 1'b1;
      fifo_seq = 0;

      // A full FIFO packet from word 0; CPU still waiting so it takes over after.
      for (int w = 0; w < 256; w++) begin
         fifo_data_i = iq_of(w, 3);
         #1;
         chk($sformatf("p4_mode_w%0d", w), {31'b0, mode_o}, 32'h0);
         tick();
         chk($sformatf("p4_data_w%0d", w), data_o, exp_fifo(iq_of(w, 3), w, fifo_seq));
      end
      chk("p4_boundary_mode", {31'b0, mode_o}, 32'h1);
      re_i = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/a2f_pkt_sched.md
A2F_PKT_SCHED -- requirements
Module: a2f_pkt_sched

Interface
REQ-001 SHALL have parameter FT_DATA_WIDTH, default 32: FTDI word width.
REQ-002 SHALL have parameter IQ_PAIR_WIDTH, default 24: packed I/Q pair width, I in the upper half.
REQ-003 SHALL have parameter QSTART_BIT_INDEX, default 16: bit position of I within the FTDI word.
REQ-004 SHALL have parameter PKT_WORDS, default 256: words per packet, power of two, at least 2.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock, rising-edge, shared with FTDI, FIFO and CPU.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port re_i, input, 1 bit: FTDI read request, one word per cycle.
REQ-008 SHALL have port fifo_data_i, input, IQ_PAIR_WIDTH bits: FIFO word, first-word-fall-through.
REQ-009 SHALL have port fifo_empty_i, input, 1 bit: FIFO empty flag.
REQ-010 SHALL have port fifo_re_o, output, 1 bit: FIFO read strobe.
REQ-011 SHALL have port cpu_data_i, input, FT_DATA_WIDTH bits: CPU word, first-word-fall-through.
REQ-012 SHALL have port cpu_empty_i, input, 1 bit: CPU queue empty flag.
REQ-013 SHALL have port cpu_re_o, output, 1 bit: CPU read strobe.
REQ-014 SHALL have port data_o, output, FT_DATA_WIDTH bits: registered word to FTDI.
REQ-015 SHALL have port avail_o, output, 1 bit: the selected source is non-empty.
REQ-016 SHALL have port mode_o, output, 1 bit: 0 = FROMFIFO, 1 = FROMCPU.
REQ-017 SHALL have port underflow_o, output, 1 bit: one-cycle pulse marking a read while the selected source is empty.

Function
REQ-018 SHALL implement a two-state FSM, FROMFIFO and FROMCPU, whose state drives mode_o.
REQ-019 SHALL define an accepted read as re_i high while the selected source's empty flag is low.
REQ-020 SHALL drive fifo_re_o = re_i & ~fifo_empty_i & (mode==FROMFIFO), and cpu_re_o the same with the CPU signals and FROMCPU; both combinational and mutually exclusive.
REQ-021 SHALL update data_o at the rising edge after an accepted read, giving latency 1, and SHALL hold data_o otherwise.
REQ-022 SHALL pack FIFO words with fifo_data_i[23:12] at data_o[27:16], fifo_data_i[11:0] at data_o[11:0], and all other bits zero (default parameters).
REQ-023 SHALL pass CPU words unchanged.
REQ-024 SHALL keep a packet word counter of width log2(PKT_WORDS) that increments only on accepted reads and wraps from PKT_WORDS-1 to 0.
REQ-025 SHALL change state only on the accepted read at count PKT_WORDS-1; a mode never changes mid-packet.
REQ-026 At a packet boundary, the next mode SHALL be FROMCPU if cpu_empty_i is 0, else FROMFIFO (CPU priority).
REQ-027 At a packet boundary from FROMCPU with both sources non-empty, the next mode SHALL be FROMFIFO (anti-starvation alternation).
REQ-028 SHALL pulse underflow_o high for one cycle when re_i is high and the selected source is empty; no strobe, no count change and no data_o change SHALL occur that cycle.
REQ-029 SHALL drive avail_o combinationally as the inverse of the selected source's empty flag.
REQ-030 If the non-selected source becomes non-empty mid-packet, there SHALL be no effect until the packet boundary.

Reset
REQ-031 While reset_n is low, the block SHALL hold: state FROMFIFO, counter 0, data_o 0, underflow_o 0.
REQ-032 A reset mid-packet SHALL abandon the packet; counting SHALL restart at word 0 in FROMFIFO.
REQ-033 The read strobes SHALL be forced low while reset_n is low.

Configuration
REQ-034 SHALL provide the macro A2F_PKT_TAG_EN.
REQ-035 With A2F_PKT_TAG_EN defined, FIFO words SHALL carry data_o[31] = 1 on packet word 0, and data_o[30:28] = the low 3 bits of a packet sequence number that increments per completed FIFO packet and resets to 0.
REQ-036 Without A2F_PKT_TAG_EN, bits 31:28 SHALL be zero and the sequence counter SHALL be absent.

Structure
REQ-037 Package a2f_pkg SHALL hold the mode encoding (FROMFIFO=0, FROMCPU=1) and the default width constants.
REQ-038 Sub-module a2f_iq_pack SHALL perform the combinational I/Q packing of REQ-022 and the tag insertion of REQ-035.

Verification
REQ-039 The bench SHALL cover: FIFO only, fifo_data_i=24'hABC123, re_i high one cycle -> data_o=32'h0ABC_0123 next cycle, fifo_re_o high 1 cycle.
REQ-040 The bench SHALL cover: CPU made non-empty at word 10 of a FIFO packet, continuous re_i -> mode_o stays 0 through word 255, then 1 from word 0 of the next packet.
REQ-041 The bench SHALL cover: both sources non-empty, 3 packets -> sequence CPU, FIFO, CPU.
REQ-042 The bench SHALL cover: FROMFIFO with fifo_empty_i=1 and re_i=1 -> underflow_o pulses, fifo_re_o=0, counter and data_o unchanged.
REQ-043 The bench SHALL cover: reset_n low at word 100 of a CPU packet -> mode_o=0 and data_o=0 immediately; the next FIFO read is counted as word 0.
REQ-044 The bench SHALL cover, with A2F_PKT_TAG_EN defined: two FIFO packets -> the first word of each has bit 31 = 1 and bits 30:28 = 0 then 1; all other words have bit 31 = 0.
